instr_fetch: RTL

- Read-side master for the synchronous instruction ROM.
- Owns the program counter and drives the ROM word address.
- Absorbs the ROM's fixed 1-cycle registered read latency.
- Presents instruction and PC pairs to decode over a valid/ready handshake, with branch/jump redirect and full stall support.

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 25 ++
 rtl/fetch_skid_buf.sv | 96 +++++++++
 rtl/instr_fetch.sv | 108 ++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t PC_STEP          = 32'd4;
    localparam pc_t DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte PC to word index. The caller keeps the low ADDR_W bits, which
    // makes PCs beyond the ROM alias back onto it.
    function automatic logic [PC_W-3:0] pc_to_word(input pc_t pc);
        return (PC_W-2)'(pc >> 2);
    endfunction

    // Instructions are word aligned; the two low PC bits are ignored.
    function automatic pc_t pc_align(input pc_t pc);
        return pc & ~pc_t'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake: instruction plus its PC, valid/ready.
interface instr_fetch_if #(
    parameter int DATA_W = instr_fetch_pkg::INSTR_W
);
    logic                               instr_valid;
    logic                               instr_ready;
    logic [DATA_W-1:0]                  instr;
    logic [instr_fetch_pkg::PC_W-1:0]   instr_pc;

    // Fetch unit drives the instruction stream.
    modport master (
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    // Decode consumes it.
    modport slave (
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer (out slot + skid slot) for {instr, pc}.
// Returning ROM data fills the first free slot; the out slot drains on
// fire and is refilled from skid first so ordering is preserved.
module fetch_skid_buf
    import instr_fetch_pkg::*;
#(
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  pc_t               in_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output pc_t               out_pc,
    output logic [1:0]        count
);

    logic              out_valid_reg,  out_valid_next;
    logic [DATA_W-1:0] out_instr_reg,  out_instr_next;
    pc_t               out_pc_reg,     out_pc_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_instr_reg, skid_instr_next;
    pc_t               skid_pc_reg,    skid_pc_next;

    logic fire;
    logic out_free;

    // Slot steering: drain on fire, refill from skid, else from returning data.
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_instr_next  = out_instr_reg;
        out_pc_next     = out_pc_reg;
        skid_valid_next = skid_valid_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;

        fire     = out_valid_reg && out_ready;
        out_free = !out_valid_reg || fire;

        if (flush) begin
            // A fire this cycle has already completed; everything else goes.
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_instr_next  = skid_instr_reg;
                out_pc_next     = skid_pc_reg;
                skid_valid_next = in_valid;
                if (in_valid) begin
                    skid_instr_next = in_instr;
                    skid_pc_next    = in_pc;
                end
            end else if (in_valid) begin
                out_valid_next = 1'b1;
                out_instr_next = in_instr;
                out_pc_next    = in_pc;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (in_valid) begin
            skid_valid_next = 1'b1;
            skid_instr_next = in_instr;
            skid_pc_next    = in_pc;
        end
    end

    // Slot registers; reset clears the visible instruction and PC to zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_valid_reg  <= 1'b0;
            out_instr_reg  <= '0;
            out_pc_reg     <= '0;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= '0;
            skid_pc_reg    <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_instr_reg  <= out_instr_next;
            out_pc_reg     <= out_pc_next;
            skid_valid_reg <= skid_valid_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_pc    = out_pc_reg;
    assign count     = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues ROM reads, hides the ROM's
// one-cycle read latency and hands {instr, pc} to decode with full stall
// and redirect support.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int  ADDR_W   = 10,
    parameter int  DATA_W   = INSTR_W,
    parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  pc_t               redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    instr_fetch_if.master     dec
);

    pc_t  pc_reg, pc_next;
    logic inflight_valid_reg, inflight_valid_next;
    pc_t  inflight_pc_reg, inflight_pc_next;

    logic              fire;
    logic              issue;
    logic [1:0]        buf_count;
    logic [1:0]        occ;
    logic [1:0]        occ_after_fire;
    pc_t               redirect_aligned;
    pc_t               issue_pc;
    logic [PC_W-3:0]   word_full;

    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    pc_t               out_pc;

    // Issue decision and ROM address. A read may only issue when, after
    // this cycle's fire, at most one slot is committed, so the returning
    // word always has somewhere to land. A redirect flushes everything,
    // so it can always issue.
    always_comb begin
        fire             = out_valid && dec.instr_ready;
        occ              = buf_count + {1'b0, inflight_valid_reg};
        occ_after_fire   = occ - {1'b0, fire};
        redirect_aligned = pc_align(redirect_pc);
        issue_pc         = redirect_valid ? redirect_aligned : pc_reg;
        issue            = fetch_en && !reset &&
                           (redirect_valid || (occ_after_fire < 2'd2));
        word_full        = pc_to_word(issue_pc);
        rom_addr         = word_full[ADDR_W-1:0];
    end

    // Next PC and in-flight read tracking.
    always_comb begin
        pc_next             = pc_reg;
        inflight_valid_next = 1'b0;
        inflight_pc_next    = inflight_pc_reg;
        if (issue) begin
            inflight_valid_next = 1'b1;
            inflight_pc_next    = issue_pc;
            pc_next             = issue_pc + PC_STEP;
        end else if (redirect_valid) begin
            pc_next = redirect_aligned;
        end
    end

    // PC and in-flight registers; reset discards any outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg             <= RESET_PC;
            inflight_valid_reg <= 1'b0;
            inflight_pc_reg    <= '0;
        end else begin
            pc_reg             <= pc_next;
            inflight_valid_reg <= inflight_valid_next;
            inflight_pc_reg    <= inflight_pc_next;
        end
    end

    fetch_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .srst      (reset),
        .flush     (redirect_valid),
        .in_valid  (inflight_valid_reg),
        .in_instr  (rom_dout),
        .in_pc     (inflight_pc_reg),
        .out_ready (dec.instr_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (buf_count)
    );

    assign dec.instr_valid = out_valid;
    assign dec.instr       = out_instr;
    assign dec.instr_pc    = out_pc;

    // Word bits above the ROM range are intentionally dropped (aliasing).
    logic unused_word_bits;
    assign unused_word_bits = ^word_full[PC_W-3:ADDR_W];

    // Buffer plus in-flight read must never exceed the two slots.
    occ_bounded: assert property (@(posedge clk) disable iff (reset) occ <= 2'd2);

endmodule
